// File: rtl/lock_pkg.sv
// Shared types and constants for the keypad code lock.
// Imported by the key decoder and the lock controller.
package lock_pkg;

    localparam int KEY_STAR = 10;
    localparam int KEY_HASH = 11;
    localparam int DIGIT_W  = 4;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ENTRY,
        S_CHECK,
        S_OPEN,
        S_CHG_OLD,
        S_CHK_OLD,
        S_CHG_NEW,
        S_CHG_CONF,
        S_CHK_NEW,
        S_LOCKOUT
    } state_t;

    function automatic logic key_is_onehot(input logic [11:0] k);
        return (k != '0) && ((k & (k - 12'd1)) == '0);
    endfunction

endpackage

// File: rtl/code_lock_ctrl_key_event_decoder.sv
// Turns the raw one-hot keypad lines into single press events.
// A new event needs an all-zero sample first, so holds never repeat.
module key_event_decoder
    import lock_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic [11:0]        key_in,
    output logic               key_evt,
    output logic [DIGIT_W-1:0] key_code
);

    logic               armed;
    logic               press;
    logic [DIGIT_W-1:0] idx;

    assign press = armed && key_is_onehot(key_in);

    // Binary index of the pressed key; only meaningful when one-hot
    always_comb begin
        idx = '0;
        for (int i = 11; i >= 0; i--) begin
            if (key_in[i]) idx = DIGIT_W'(i);
        end
    end

    // Re-arm on an idle sample; emit one registered event per press
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            armed    <= 1'b0;
            key_evt  <= 1'b0;
            key_code <= '0;
        end else begin
            armed   <= (key_in == '0);
            key_evt <= press;
            if (press) key_code <= idx;
        end
    end

endmodule

// File: rtl/code_lock_ctrl.sv
// Keypad code lock: entry, verify, code change, open pulse, lockout.
// One shared cycle counter serves open time, lockout time and timeout.
module code_lock_ctrl
    import lock_pkg::*;
#(
    parameter int CODE_LEN    = 6,
    parameter int MAX_FAIL    = 3,
    parameter int OPEN_CYC    = 500,
    parameter int LOCKOUT_CYC = 1000,
    parameter int TIMEOUT_CYC = 5000,
    parameter logic [CODE_LEN*DIGIT_W-1:0] INIT_CODE = 24'h123456
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [11:0]                   inputChar,
    output logic                          open,
    output logic                          locked_out,
    output logic                          err,
    output logic                          chg_done,
    output logic [$clog2(MAX_FAIL+1)-1:0] fail_cnt,
    output logic [$clog2(CODE_LEN+1)-1:0] digits_in
);

    localparam int CW = CODE_LEN * DIGIT_W;
    localparam int FW = $clog2(MAX_FAIL + 1);
    localparam int DW = $clog2(CODE_LEN + 1);
    localparam int CNT_MAX =
        (OPEN_CYC > LOCKOUT_CYC)
            ? ((OPEN_CYC > TIMEOUT_CYC) ? OPEN_CYC : TIMEOUT_CYC)
            : ((LOCKOUT_CYC > TIMEOUT_CYC) ? LOCKOUT_CYC : TIMEOUT_CYC);
    localparam int TW = $clog2(CNT_MAX + 1);

    state_t             state, state_n;
    logic [CW-1:0]      code_q, code_n;
    logic [CW-1:0]      entry_q, entry_n;
    logic [CW-1:0]      cand_q, cand_n;
    logic [CW-1:0]      shifted;
    logic [DW-1:0]      digits_n;
    logic [FW-1:0]      fail_n;
    logic [TW-1:0]      cnt_q, cnt_n;
    logic               key_evt;
    logic [DIGIT_W-1:0] key_code;
    logic               is_dig, is_star, is_hash;
    logic               last_dig, restart;
    logic               code_ok, conf_ok;

    key_event_decoder u_keys (
        .clk      (clk),
        .reset_n  (reset_n),
        .key_in   (inputChar),
        .key_evt  (key_evt),
        .key_code (key_code)
    );

    assign is_dig  = key_evt && (key_code <= DIGIT_W'(9));
    assign is_star = key_evt && (key_code == DIGIT_W'(KEY_STAR));
    assign is_hash = key_evt && (key_code == DIGIT_W'(KEY_HASH));

    assign shifted  = {entry_q[CW-DIGIT_W-1:0], key_code};
    assign last_dig = (digits_in == DW'(CODE_LEN - 1));
    assign code_ok  = (entry_q == code_q);
    assign conf_ok  = (entry_q == cand_q);

    assign open       = (state == S_OPEN);
    assign locked_out = (state == S_LOCKOUT);
    assign chg_done   = (state == S_CHK_NEW) && conf_ok;
    assign err        = ((state == S_CHECK || state == S_CHK_OLD) && !code_ok)
                     || ((state == S_CHK_NEW) && !conf_ok);

    // Next state, entry datapath and shared cycle counter
    always_comb begin
        state_n  = state;
        entry_n  = entry_q;
        cand_n   = cand_q;
        code_n   = code_q;
        digits_n = digits_in;
        fail_n   = fail_cnt;
        restart  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (is_dig) begin
                    entry_n  = shifted;
                    digits_n = DW'(1);
                    state_n  = S_ENTRY;
                end else if (is_star) begin
                    digits_n = '0;
                    state_n  = S_CHG_OLD;
                end
            end
            S_ENTRY, S_CHG_OLD, S_CHG_NEW, S_CHG_CONF: begin
                restart = key_evt;
                if (is_hash) begin
                    entry_n  = '0;
                    cand_n   = '0;
                    digits_n = '0;
                    state_n  = S_IDLE;
                end else if (is_dig) begin
                    entry_n  = shifted;
                    digits_n = digits_in + 1'b1;
                    if (last_dig) begin
                        if (state == S_ENTRY) begin
                            state_n = S_CHECK;
                        end else if (state == S_CHG_OLD) begin
                            state_n = S_CHK_OLD;
                        end else if (state == S_CHG_NEW) begin
                            cand_n   = shifted;
                            entry_n  = '0;
                            digits_n = '0;
                            state_n  = S_CHG_CONF;
                        end else begin
                            state_n = S_CHK_NEW;
                        end
                    end
                end else if (!key_evt && cnt_q >= TW'(TIMEOUT_CYC - 1)) begin
                    entry_n  = '0;
                    cand_n   = '0;
                    digits_n = '0;
                    state_n  = S_IDLE;
                end
            end
            S_CHECK, S_CHK_OLD: begin
                entry_n  = '0;
                digits_n = '0;
                if (code_ok) begin
                    fail_n  = '0;
                    state_n = (state == S_CHECK) ? S_OPEN : S_CHG_NEW;
                end else begin
                    fail_n  = fail_cnt + 1'b1;
                    state_n = (fail_cnt == FW'(MAX_FAIL - 1))
                              ? S_LOCKOUT : S_IDLE;
                end
            end
            S_CHK_NEW: begin
                if (conf_ok) code_n = cand_q;
                entry_n  = '0;
                cand_n   = '0;
                digits_n = '0;
                state_n  = S_IDLE;
            end
            S_OPEN: begin
                if (is_hash || cnt_q >= TW'(OPEN_CYC - 1)) state_n = S_IDLE;
            end
            S_LOCKOUT: begin
                if (cnt_q >= TW'(LOCKOUT_CYC - 1)) begin
                    fail_n  = '0;
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
        if (state_n != state || restart) begin
            cnt_n = '0;
        end else if (cnt_q != TW'(CNT_MAX)) begin
            cnt_n = cnt_q + 1'b1;
        end else begin
            cnt_n = cnt_q;
        end
    end

    // State, buffers, code register and counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            code_q    <= INIT_CODE;
            entry_q   <= '0;
            cand_q    <= '0;
            digits_in <= '0;
            fail_cnt  <= '0;
            cnt_q     <= '0;
        end else begin
            state     <= state_n;
            code_q    <= code_n;
            entry_q   <= entry_n;
            cand_q    <= cand_n;
            digits_in <= digits_n;
            fail_cnt  <= fail_n;
            cnt_q     <= cnt_n;
        end
    end

endmodule

// File: tb/tb_code_lock_ctrl.sv
// Scoreboard bench for code_lock_ctrl with default parameters.
// Stimulus queues expected events; a monitor pops them as outputs fire.
module tb_code_lock_ctrl;

    localparam int K_ERR  = 0;
    localparam int K_CHG  = 1;
    localparam int K_OPEN = 2;
    localparam int K_LOCK = 3;
    localparam int STAR   = 10;
    localparam int HASH   = 11;

    typedef struct {
        int kind;
        int val;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic [11:0] inputChar;
    logic        open;
    logic        locked_out;
    logic        err;
    logic        chg_done;
    logic [1:0]  fail_cnt;
    logic [2:0]  digits_in;

    exp_t exp_q[$];
    int   checks;
    int   errors;

    code_lock_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .inputChar  (inputChar),
        .open       (open),
        .locked_out (locked_out),
        .err        (err),
        .chg_done   (chg_done),
        .fail_cnt   (fail_cnt),
        .digits_in  (digits_in)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic push(input int kind, input int val);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic take(input int kind, output int val);
        exp_t e;
        checks++;
        val = 0;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind %0d want none", kind);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind) begin
                errors++;
                $display("FAIL event_kind: got %0d want %0d", kind, e.kind);
            end
            val = e.val;
        end
    endtask

    task automatic press(input int k, input int hold);
        @(negedge clk);
        inputChar = 12'd1 << k;
        repeat (hold) @(negedge clk);
        inputChar = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic enter_code(input logic [23:0] c);
        for (int i = 0; i < 6; i++) press(int'(c[4*(5-i) +: 4]), 3);
    endtask

    // Monitor: pops an expectation for every output event it observes
    initial begin : monitor
        int v;
        int open_len, open_want, lock_len, lock_want, fc_want;
        bit fc_pend, open_q, lock_q;
        open_len = 0; open_want = 0; lock_len = 0; lock_want = 0;
        fc_want = 0; fc_pend = 0; open_q = 0; lock_q = 0;
        forever begin
            @(negedge clk);
            if (fc_pend) begin
                chk("fail_cnt_after_err", int'(fail_cnt), fc_want);
                fc_pend = 0;
            end
            if (err) begin
                take(K_ERR, v);
                fc_want = v;
                fc_pend = 1;
            end
            if (chg_done) take(K_CHG, v);
            if (open && !open_q) begin
                take(K_OPEN, v);
                open_want = v;
                open_len  = 0;
            end
            if (open) open_len++;
            if (!open && open_q && open_want > 0)
                chk("open_len", open_len, open_want);
            if (locked_out && !lock_q) begin
                take(K_LOCK, v);
                lock_want = v;
                lock_len  = 0;
            end
            if (locked_out) lock_len++;
            if (!locked_out && lock_q && lock_want > 0)
                chk("lockout_len", lock_len, lock_want);
            open_q = open;
            lock_q = locked_out;
        end
    end

    initial begin : stim
        checks    = 0;
        errors    = 0;
        reset_n   = 1'b0;
        inputChar = '0;
        repeat (3) @(negedge clk);
        chk("rst_open", int'(open), 0);
        chk("rst_locked", int'(locked_out), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_chg", int'(chg_done), 0);
        chk("rst_fail", int'(fail_cnt), 0);
        chk("rst_digits", int'(digits_in), 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Unlock with exact latency and full open duration
        push(K_OPEN, 500);
        for (int i = 1; i <= 5; i++) press(i, 3);
        @(negedge clk);
        inputChar = 12'd1 << 6;
        @(posedge clk); #1;
        chk("open_lat_e0", int'(open), 0);
        @(posedge clk); #1;
        chk("open_lat_e1", int'(open), 0);
        @(posedge clk); #1;
        chk("open_lat_e2", int'(open), 1);
        chk("fail_unlock", int'(fail_cnt), 0);
        @(negedge clk);
        inputChar = '0;
        repeat (520) @(negedge clk);
        chk("open_closed", int'(open), 0);

        // Held key, multi-bit input, inter-key timeout
        press(5, 50);
        chk("hold_one_digit", int'(digits_in), 1);
        @(negedge clk);
        inputChar = 12'h003;
        repeat (3) @(negedge clk);
        inputChar = '0;
        repeat (2) @(negedge clk);
        chk("multibit_no_evt", int'(digits_in), 1);
        press(1, 3);
        press(2, 3);
        chk("digits_three", int'(digits_in), 3);
        repeat (5010) @(negedge clk);
        chk("timeout_clear", int'(digits_in), 0);
        chk("timeout_fail", int'(fail_cnt), 0);

        // Mismatched confirmation keeps the old code
        push(K_ERR, 0);
        press(STAR, 3);
        enter_code(24'h123456);
        enter_code(24'h111111);
        enter_code(24'h222222);
        push(K_OPEN, 0);
        enter_code(24'h123456);
        chk("old_code_opens", int'(open), 1);
        press(HASH, 3);
        chk("hash_closes", int'(open), 0);

        // Successful code change
        push(K_CHG, 0);
        press(STAR, 3);
        enter_code(24'h123456);
        enter_code(24'h654321);
        enter_code(24'h654321);
        push(K_ERR, 1);
        enter_code(24'h123456);
        push(K_OPEN, 0);
        enter_code(24'h654321);
        chk("new_code_opens", int'(open), 1);
        chk("fail_after_open", int'(fail_cnt), 0);

        // Asynchronous reset while open restores INIT_CODE
        #2 reset_n = 1'b0;
        #1;
        chk("rst_in_open", int'(open), 0);
        chk("rst_in_open_fail", int'(fail_cnt), 0);
        @(negedge clk);
        reset_n = 1'b1;
        push(K_OPEN, 0);
        enter_code(24'h123456);
        chk("init_after_rst", int'(open), 1);
        press(HASH, 3);
        chk("hash_closes2", int'(open), 0);

        // Lockout after three failures; keys ignored meanwhile
        push(K_ERR, 1);
        push(K_ERR, 2);
        push(K_ERR, 3);
        push(K_LOCK, 1000);
        enter_code(24'h000000);
        enter_code(24'h000000);
        enter_code(24'h000000);
        chk("locked", int'(locked_out), 1);
        enter_code(24'h123456);
        chk("locked_digits", int'(digits_in), 0);
        for (int n = 0; n < 1200 && locked_out; n++) @(negedge clk);
        chk("lockout_exit", int'(locked_out), 0);
        chk("fail_after_lock", int'(fail_cnt), 0);

        // Asynchronous reset during lockout
        push(K_ERR, 1);
        push(K_ERR, 2);
        push(K_ERR, 3);
        push(K_LOCK, 0);
        enter_code(24'h999999);
        enter_code(24'h999999);
        enter_code(24'h999999);
        repeat (10) @(negedge clk);
        chk("locked2", int'(locked_out), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_in_lock", int'(locked_out), 0);
        chk("rst_in_lock_fail", int'(fail_cnt), 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        chk("pending_events", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/code_lock_ctrl.md
Name: code_lock_ctrl

Overview:
- Parametrised keypad code-lock controller; next generation of the team's fixed 6-digit door lock.
- Adds configurable code length, a user code-change flow with confirmation, press-edge key detection, inter-key timeout, a timed open pulse and a failed-attempt lockout.
- Sits between the 12-key one-hot keypad scanner and the door actuator/status LEDs.

Parameters:
- CODE_LEN, 6: digits per code, range 2..16.
- MAX_FAIL, 3: consecutive failed verifications that trigger lockout, at least 1.
- OPEN_CYC, 500: cycles open is held high.
- LOCKOUT_CYC, 1000: cycles keys are ignored after MAX_FAIL failures.
- TIMEOUT_CYC, 5000: idle cycles between key events before a partial entry is discarded.
- INIT_CODE, 24'h123456: reset code, 4 bits per digit; the most-significant nibble is entered first. Width is CODE_LEN*4.

Ports:
- clk, input, 1: single clock; all logic on its rising edge.
- reset_n, input, 1: asynchronous active-low reset.
- inputChar, input, 12: one-hot keys. Bits 0-9 are digits 0-9, bit 10 is '*', bit 11 is '#'.
- open, output, 1: door open drive.
- locked_out, output, 1: high during lockout.
- err, output, 1: one-cycle pulse on a failed verify or a failed change confirmation.
- chg_done, output, 1: one-cycle pulse when a new code is committed.
- fail_cnt, output, $clog2(MAX_FAIL+1): current consecutive-failure count.
- digits_in, output, $clog2(CODE_LEN+1): digits collected in the current entry phase, for the display.

Behaviour:
- Reset:
  - All outputs go to 0, the FSM goes to IDLE, and the entry buffers are cleared.
  - The code register reloads INIT_CODE; a changed code is not retained across reset.
- Key events:
  - An event fires when inputChar changes from all-zero to exactly one bit set.
  - It is registered as key_evt plus a 4-bit key code one cycle after the sampling edge.
  - No further event fires until inputChar has been all-zero for at least one sampled cycle.
  - A multi-bit input generates no event and still counts as "held".
- Digit entry: each accepted digit shifts into an entry buffer from the LSB, and digits_in increments.
- FSM states: IDLE, ENTRY, CHECK, OPEN, CHG_OLD, CHK_OLD, CHG_NEW, CHG_CONF, CHK_NEW, LOCKOUT.
- IDLE:
  - A digit stores as the first digit and moves to ENTRY.
  - '*' moves to CHG_OLD with digits_in=0.
  - '#' is ignored.
- ENTRY, CHG_OLD, CHG_NEW, CHG_CONF:
  - Digits accumulate.
  - '#' cancels: buffers clear, return to IDLE, no err, fail_cnt unchanged.
  - '*' is ignored.
  - On the CODE_LEN-th digit:
    - ENTRY goes to CHECK.
    - CHG_OLD goes to CHK_OLD.
    - CHG_NEW saves the buffer as the candidate and goes to CHG_CONF with digits_in=0.
    - CHG_CONF goes to CHK_NEW.
- CHECK and CHK_OLD (one cycle each, full-width equality against the code register):
  - Match: fail_cnt clears. CHECK goes to OPEN and CHK_OLD goes to CHG_NEW.
  - Mismatch: err pulses and fail_cnt increments. If fail_cnt reaches MAX_FAIL, go to LOCKOUT; otherwise go to IDLE.
- CHK_NEW:
  - Candidate equal to the confirmation: the code register updates, chg_done pulses, go to IDLE.
  - Not equal: err pulses, the code is unchanged, fail_cnt is unchanged, go to IDLE.
- Unlock latency: open rises after the second rising edge following the edge that first sampled the final digit press.
- OPEN:
  - open=1 for exactly OPEN_CYC cycles, then 0, then return to IDLE.
  - '#' during OPEN ends it early; open falls one cycle after the '#' event.
  - Other keys are ignored.
- LOCKOUT:
  - locked_out=1 for LOCKOUT_CYC cycles, and all key events are ignored.
  - On exit, fail_cnt clears and the FSM goes to IDLE.
  - A key still held at exit produces no event until it is released.
- Timeout:
  - Applies in ENTRY, CHG_OLD, CHG_NEW and CHG_CONF.
  - If TIMEOUT_CYC cycles pass with no event, buffers clear and the FSM returns to IDLE silently, with no err and no fail change.
  - Every event restarts the timer.
- Counters:
  - One shared cycle counter, sized for max(OPEN_CYC, LOCKOUT_CYC, TIMEOUT_CYC).
  - It reloads on every state change.
  - It saturates and never wraps.
- Reset mid-operation: reset_n asserted in any state, including OPEN or LOCKOUT, returns everything to reset values immediately (asynchronously).

Decomposition:
- Shared package lock_pkg holds:
  - KEY_STAR=10 and KEY_HASH=11.
  - The FSM state enum.
  - The DIGIT_W=4 constant.
  - A function that validates one-hot input.
- One sub-module, key_event_decoder: one-hot validation, press-edge and release detection, registered key code and key_evt.
- The FSM, counters and code register stay in code_lock_ctrl.

Test Plan:
- Unlock: keys 1,2,3,4,5,6, each press 3 cycles, release 2 cycles -> open rises 2 edges after the edge that sampled '6', stays high for 500 cycles, fail_cnt=0.
- Lockout: three wrong codes 000000 -> err pulses three times, fail_cnt counts 1,2,3, then locked_out=1 for 1000 cycles. A correct code entered during lockout gives no open. After lockout, fail_cnt=0.
- Code change: '*', 123456, 654321, 654321 -> chg_done pulse. Then 123456 -> err. Then 654321 -> open.
- Mismatched confirm: '*', 123456, 111111, 222222 -> err pulse, fail_cnt unchanged, 123456 still opens.
- Key handling:
  - Holding '5' for 50 cycles counts as one digit (digits_in=1).
  - inputChar=12'h003 gives no event.
  - After digits 1,2,3, 5000 idle cycles -> digits_in returns to 0, no err.
- Reset: assert reset_n low in OPEN and in LOCKOUT -> open, locked_out and fail_cnt are 0 immediately. After a code change followed by reset, INIT_CODE opens again.
